// File: rtl/wptr_full_handler.sv
// Write-side pointer and flag logic for an asynchronous FIFO: binary/Gray write
// pointers, read-pointer synchronizer, full/almost_full, occupancy and sticky overflow.
module wptr_full_handler #(
   parameter int PTR_WIDTH = 3,
   parameter int AF_LEVEL  = 6
) (
   input  logic                 wclk,
   input  logic                 wrst,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   g_rptr,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic                 full,
   output logic                 almost_full,
   output logic [PTR_WIDTH:0]   wr_count,
   output logic                 overflow
);

   localparam logic [PTR_WIDTH:0] AF_THR = (PTR_WIDTH+1)'(AF_LEVEL);

   logic [PTR_WIDTH:0] g_rptr_s1;
   logic [PTR_WIDTH:0] g_rptr_s;
   logic [PTR_WIDTH:0] b_rptr_s;
   logic [PTR_WIDTH:0] b_wptr_nx;
   logic [PTR_WIDTH:0] g_wptr_nx;
   logic [PTR_WIDTH:0] full_ref;
   logic [PTR_WIDTH:0] occ_nx;
   logic               accept;

   function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
      logic [PTR_WIDTH:0] b;
      b[PTR_WIDTH] = g[PTR_WIDTH];
      for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      accept    = w_en & ~full;
      b_wptr_nx = b_wptr + {{PTR_WIDTH{1'b0}}, accept};
      g_wptr_nx = b_wptr_nx ^ (b_wptr_nx >> 1);
      b_rptr_s  = gray2bin(g_rptr_s);
      // Writer is a full lap ahead when the top two Gray bits differ and the rest match.
      full_ref  = {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]};
      occ_nx    = b_wptr_nx - b_rptr_s;
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         g_rptr_s1   <= '0;
         g_rptr_s    <= '0;
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_count    <= '0;
         overflow    <= 1'b0;
      end else begin
         g_rptr_s1   <= g_rptr;
         g_rptr_s    <= g_rptr_s1;
         b_wptr      <= b_wptr_nx;
         g_wptr      <= g_wptr_nx;
         full        <= (g_wptr_nx == full_ref);
         almost_full <= (occ_nx >= AF_THR);
         wr_count    <= occ_nx;
         if (w_en && full) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full_handler.sv
// Directed bench for wptr_full_handler (PTR_WIDTH=3, AF_LEVEL=6): vector table for
// reset/fill/overflow/drain, plus hand sequences for pointer wrap and mid-run reset.
module tb_wptr_full_handler;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       w_en;
   logic [3:0] g_rptr;
   logic [3:0] b_wptr;
   logic [3:0] g_wptr;
   logic       full;
   logic       almost_full;
   logic [3:0] wr_count;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   wptr_full_handler #(.PTR_WIDTH(3), .AF_LEVEL(6)) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .w_en        (w_en),
      .g_rptr      (g_rptr),
      .b_wptr      (b_wptr),
      .g_wptr      (g_wptr),
      .full        (full),
      .almost_full (almost_full),
      .wr_count    (wr_count),
      .overflow    (overflow)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic       rst;
      logic       wen;
      logic [3:0] grp;
      logic [3:0] eb;
      logic [3:0] eg;
      logic       ef;
      logic       eaf;
      logic [3:0] ewc;
      logic       eov;
   } vec_t;

   vec_t vecs[18];

   function automatic logic [3:0] bin2gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [3:0] eb, input logic [3:0] eg, input logic ef,
                            input logic eaf, input logic [3:0] ewc, input logic eov);
      check("b_wptr", idx, b_wptr, eb);
      check("g_wptr", idx, g_wptr, eg);
      check("full", idx, {3'b0, full}, {3'b0, ef});
      check("almost_full", idx, {3'b0, almost_full}, {3'b0, eaf});
      check("wr_count", idx, wr_count, ewc);
      check("overflow", idx, {3'b0, overflow}, {3'b0, eov});
   endtask

   task automatic step(input logic r, input logic w, input logic [3:0] g);
      wrst   = r;
      w_en   = w;
      g_rptr = g;
      @(posedge wclk);
      #1;
   endtask

   initial begin
      logic [3:0] wb;
      logic [3:0] rdrv;
      logic [3:0] ewc;

      //            rst   wen   grp    b      g      f     af    wc     ov
      vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 4'h0, 4'h2, 4'h3, 1'b0, 1'b0, 4'h2, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 4'h0, 4'h3, 4'h2, 1'b0, 1'b0, 4'h3, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'h0, 4'h4, 4'h6, 1'b0, 1'b0, 4'h4, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'h0, 4'h5, 4'h7, 1'b0, 1'b0, 4'h5, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0, 1'b1, 4'h6, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'h7, 4'h4, 1'b0, 1'b1, 4'h7, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 4'h0, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b1};
      // Read pointer moves to 1 here; the flags follow on the third edge.
      vecs[14] = '{1'b0, 1'b0, 4'h1, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 4'h1, 4'h8, 4'hC, 1'b1, 1'b1, 4'h8, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 4'h1, 4'h8, 4'hC, 1'b0, 1'b1, 4'h7, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 4'h1, 4'h8, 4'hC, 1'b0, 1'b1, 4'h7, 1'b1};

      wrst = 1'b1; w_en = 1'b0; g_rptr = 4'h0;
      @(negedge wclk);

      for (int i = 0; i < 18; i++) begin
         step(vecs[i].rst, vecs[i].wen, vecs[i].grp);
         check_all(i, vecs[i].eb, vecs[i].eg, vecs[i].ef, vecs[i].eaf, vecs[i].ewc, vecs[i].eov);
      end

      // Wrap: the read pointer is driven one behind the write pointer, which after
      // the 2-flop sync and output register leaves four entries outstanding.
      step(1'b1, 1'b0, 4'h0);
      wb = 4'h0;
      for (int i = 0; i < 24; i++) begin
         rdrv = (i == 0) ? 4'h0 : bin2gray(wb - 4'h1);
         step(1'b0, 1'b1, rdrv);
         wb  = wb + 4'h1;
         ewc = (i < 3) ? 4'(i + 1) : 4'h4;
         check_all(100 + i, wb, bin2gray(wb), 1'b0, 1'b0, ewc, 1'b0);
      end
      check("wrap_b_wptr", 200, b_wptr, 4'h8);

      // Mid-run reset: park the read pointer at 13 so the FIFO fills at b_wptr=5.
      step(1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, bin2gray(4'd13));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, bin2gray(4'd13));
      check_all(300, 4'h5, 4'h7, 1'b1, 1'b1, 4'h8, 1'b0);
      step(1'b0, 1'b1, bin2gray(4'd13));
      check_all(301, 4'h5, 4'h7, 1'b1, 1'b1, 4'h8, 1'b1);
      step(1'b1, 1'b1, 4'h0);
      check_all(302, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b0, 1'b1, 4'h0);
      check_all(303, 4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
